// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 register slave: FSM states, pprot bit
// positions and the byte-offset width helper used for address decode.
package apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_t;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_SECURE_BIT = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    // Number of paddr bits that select a byte within one data word.
    function automatic int byteOffsetWidth(input int dataW);
        return $clog2(dataW / 8);
    endfunction

endpackage

// File: rtl/apb4_reg_bank.sv
// Register storage for the APB4 slave: byte-strobed writes, hardware-sourced
// read-only slots and the read multiplexer.
module apb4_reg_bank
    import apb4_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter int                  IDX_W    = 10,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_wen,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [DATA_W/8-1:0]          i_strb,
    input  logic [NUM_REGS*DATA_W-1:0]   i_hw_in,
    output logic [NUM_REGS*DATA_W-1:0]   o_reg_q,
    output logic [DATA_W-1:0]            o_rdata
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wen) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_idx == IDX_W'(i) && !RO_MASK[i]) begin
                    for (int b = 0; b < DATA_W / 8; b++) begin
                        if (i_strb[b]) begin
                            r_regs[i][8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read-only slots expose the hardware value rather than local storage.
    always_comb begin
        o_reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? i_hw_in[i*DATA_W +: DATA_W] : r_regs[i];
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_rdata = o_reg_q[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/apb4_reg_slave.sv
// APB4 register slave with configurable wait states and read-only slots.
// Define APB4_REG_SLAVE_PROT_EN to reject unprivileged writes (pprot[0]=0).
module apb4_reg_slave
    import apb4_pkg::*;
#(
    parameter int                  ADDR_W      = 12,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    input  logic [2:0]                   pprot,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int OFFS_W = byteOffsetWidth(DATA_W);
    localparam int IDX_W  = ADDR_W - OFFS_W;

    apb_state_t          r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_strb;
    logic [2:0]          r_prot;
    logic [3:0]          r_cnt;
    logic                r_pready;

    logic [IDX_W-1:0]    w_idx;
    logic                w_badIdx, w_badOffs, w_roHit, w_protErr, w_err, w_commit;
    logic [DATA_W-1:0]   w_rdata;

    assign w_idx     = r_addr[ADDR_W-1:OFFS_W];
    assign w_badIdx  = 32'(w_idx) >= 32'(NUM_REGS);
    assign w_badOffs = |r_addr[OFFS_W-1:0];

    always_comb begin
        w_roHit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_roHit = RO_MASK[i];
            end
        end
    end

`ifdef APB4_REG_SLAVE_PROT_EN
    assign w_protErr = r_write & ~r_prot[PPROT_PRIV_BIT];
`else
    logic w_unusedProt;
    assign w_unusedProt = ^r_prot;
    assign w_protErr    = 1'b0;
`endif

    assign w_err = w_badIdx | w_badOffs | (r_write & w_roHit) | w_protErr;

    // An all-zero strobe still completes cleanly but must not pulse.
    assign w_commit = r_pready & r_write & ~w_err & (|r_strb) & ~preset;

    always_comb begin
        wr_pulse = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse[i] = w_commit && (w_idx == IDX_W'(i));
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pready & w_err;
    assign prdata  = (r_pready & ~r_write & ~w_err) ? w_rdata : '0;

    // With no wait states the setup phase jumps straight to RESP so the
    // registered pready lands in the access cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    w_next = ST_IDLE;
                end else if (penable && r_cnt <= 4'd1) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state  <= ST_IDLE;
            r_pready <= 1'b0;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_prot   <= '0;
        end else begin
            r_state  <= w_next;
            r_pready <= (w_next == ST_RESP);
            if (r_state == ST_IDLE && psel && !penable) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
                r_prot  <= pprot;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == ST_WAIT && psel && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (w_next == ST_IDLE) begin
                r_cnt <= 4'd0;
            end
        end
    end

    apb4_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RO_MASK  (RO_MASK)
    ) u_bank (
        .i_clk   (pclk),
        .i_reset (preset),
        .i_wen   (w_commit),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .i_strb  (r_strb),
        .i_hw_in (hw_in),
        .o_reg_q (reg_q),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Self-checking bench for apb4_reg_slave: a zero-wait instance with one
// read-only slot and a three-wait-state instance sharing the APB bus.
module tb_apb4_reg_slave;

    logic         pclk = 1'b0;
    logic         preset;
    logic [11:0]  paddr;
    logic         psel0, psel3, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic [511:0] hwIn;

    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [511:0] regQ0, regQ3;
    logic [15:0]  wrPulse0, wrPulse3;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb4_reg_slave #(
        .ADDR_W(12), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0), .RO_MASK(16'h0008)
    ) dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .reg_q(regQ0), .hw_in(hwIn), .wr_pulse(wrPulse0)
    );

    apb4_reg_slave #(
        .ADDR_W(12), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(3), .RO_MASK(16'h0000)
    ) dut3 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .reg_q(regQ3), .hw_in(hwIn), .wr_pulse(wrPulse3)
    );

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        expErr;
        logic [31:0] expRdata;
        logic [15:0] expPulse;
        int          qIdx;
        logic [31:0] expQ;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Full APB transfer starting at posedge+1; leaves the bus idle at posedge+1
    // so a following call issues its setup phase in the very next cycle.
    task automatic applyStimulus(input logic [11:0] addr, input logic wr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [2:0] prot, input bit slow,
                                 output logic [31:0] rdata, output logic err,
                                 output logic [15:0] pulse, output int waits);
        bit done;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        penable = 1'b0;
        if (slow) psel3 = 1'b1;
        else      psel0 = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        pulse = '0;
        while (!done) begin
            @(negedge pclk);
            if (slow ? pready3 : pready0) begin
                rdata = slow ? prdata3 : prdata0;
                err   = slow ? pslverr3 : pslverr0;
                pulse = slow ? wrPulse3 : wrPulse0;
                done  = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pready timeout: addr=0x%0h got no pready, expected pready within 20 cycles", addr);
                    done = 1'b1;
                end
            end
        end
        @(posedge pclk); #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [15:0] pu;
    int          wt;
    bit          sawReady, sawPulse;

    initial begin
        vecs[0]  = '{12'h004, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        16'h0002, 1,  32'hDEADBEEF};
        vecs[1]  = '{12'h004, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 16'h0000, 1,  32'hDEADBEEF};
        vecs[2]  = '{12'h008, 1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0,        16'h0004, 2,  32'h11223344};
        vecs[3]  = '{12'h008, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        16'h0004, 2,  32'h11BB33DD};
        vecs[4]  = '{12'h008, 1'b0, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 16'h0000, 2,  32'h11BB33DD};
        vecs[5]  = '{12'h040, 1'b1, 32'h12345678, 4'hF, 1'b1, 32'h0,        16'h0000, 0,  32'h0};
        vecs[6]  = '{12'h006, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        16'h0000, 1,  32'hDEADBEEF};
        vecs[7]  = '{12'h00C, 1'b1, 32'h99999999, 4'hF, 1'b1, 32'h0,        16'h0000, 3,  32'hC0FFEE03};
        vecs[8]  = '{12'h00C, 1'b0, 32'h0,        4'h0, 1'b0, 32'hC0FFEE03, 16'h0000, 3,  32'hC0FFEE03};
        vecs[9]  = '{12'h03C, 1'b1, 32'h0000FFFF, 4'h0, 1'b0, 32'h0,        16'h0000, 15, 32'h0};
        vecs[10] = '{12'h03C, 1'b1, 32'h87654321, 4'hF, 1'b0, 32'h0,        16'h8000, 15, 32'h87654321};
        vecs[11] = '{12'h040, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        16'h0000, 15, 32'h87654321};
        vecs[12] = '{12'h005, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        16'h0000, 1,  32'hDEADBEEF};
        vecs[13] = '{12'h03C, 1'b0, 32'h0,        4'h0, 1'b0, 32'h87654321, 16'h0000, 15, 32'h87654321};

        for (int i = 0; i < 16; i++) hwIn[i*32 +: 32] = 32'h5A5A0000 | 32'(i);
        hwIn[3*32 +: 32] = 32'hC0FFEE03;

        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        checkOutput("reset pready0", pready0, 0);
        checkOutput("reset pslverr0", pslverr0, 0);
        checkOutput("reset prdata0", prdata0, 0);
        checkOutput("reset wr_pulse0", wrPulse0, 0);
        checkOutput("reset reg1", regQ0[32 +: 32], 0);
        checkOutput("reset pready3", pready3, 0);
        @(posedge pclk); #1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, 3'b001, 1'b0, rd, er, pu, wt);
            checkOutput($sformatf("vec%0d pslverr", i), er, vecs[i].expErr);
            checkOutput($sformatf("vec%0d wr_pulse", i), pu, vecs[i].expPulse);
            checkOutput($sformatf("vec%0d waits", i), wt, 0);
            if (!vecs[i].wr || vecs[i].expErr)
                checkOutput($sformatf("vec%0d prdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d reg_q", i), regQ0[vecs[i].qIdx*32 +: 32], vecs[i].expQ);
        end

        // wr_pulse lasts one cycle and pready drops once the bus goes idle
        applyStimulus(12'h014, 1'b1, 32'h00000055, 4'hF, 3'b001, 1'b0, rd, er, pu, wt);
        checkOutput("pulse5 during resp", pu, 16'h0020);
        @(negedge pclk);
        checkOutput("pulse5 after resp", wrPulse0, 0);
        checkOutput("pready after resp", pready0, 0);
        checkOutput("reg5 value", regQ0[5*32 +: 32], 32'h55);
        @(posedge pclk); #1;

        // privilege check on writes only
        applyStimulus(12'h010, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, rd, er, pu, wt);
`ifdef APB4_REG_SLAVE_PROT_EN
        checkOutput("unpriv write err", er, 1);
        checkOutput("unpriv write pulse", pu, 0);
        checkOutput("unpriv write reg4", regQ0[4*32 +: 32], 0);
`else
        checkOutput("unpriv write err", er, 0);
        checkOutput("unpriv write pulse", pu, 16'h0010);
        checkOutput("unpriv write reg4", regQ0[4*32 +: 32], 32'hCAFEF00D);
`endif
        applyStimulus(12'h010, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0, rd, er, pu, wt);
        checkOutput("priv write err", er, 0);
        checkOutput("priv write pulse", pu, 16'h0010);
        applyStimulus(12'h010, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, pu, wt);
        checkOutput("unpriv read err", er, 0);
        checkOutput("unpriv read data", rd, 32'hCAFEF00D);

        // three wait states on the second instance
        applyStimulus(12'h008, 1'b1, 32'h0BADCAFE, 4'hF, 3'b001, 1'b1, rd, er, pu, wt);
        checkOutput("slow write waits", wt, 3);
        checkOutput("slow write pulse", pu, 16'h0004);
        applyStimulus(12'h008, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd, er, pu, wt);
        checkOutput("slow read waits", wt, 3);
        checkOutput("slow read data", rd, 32'h0BADCAFE);
        checkOutput("slow read err", er, 0);

        // psel dropped during WAIT
        paddr = 12'h010; pwrite = 1'b1; pwdata = 32'hFFFF0000; pstrb = 4'hF; pprot = 3'b001;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
        sawReady = 1'b0; sawPulse = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            if (pready3) sawReady = 1'b1;
            if (wrPulse3 != 0) sawPulse = 1'b1;
        end
        @(posedge pclk); #1;
        checkOutput("abort pready seen", sawReady, 0);
        checkOutput("abort pulse seen", sawPulse, 0);
        checkOutput("abort reg4 slow", regQ3[4*32 +: 32], 0);

        // reset in the middle of a slow write
        paddr = 12'h014; pwrite = 1'b1; pwdata = 32'h12340000; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        sawReady = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            if (pready3) sawReady = 1'b1;
        end
        checkOutput("rst pready seen", sawReady, 0);
        checkOutput("rst pslverr3", pslverr3, 0);
        checkOutput("rst prdata3", prdata3, 0);
        checkOutput("rst wr_pulse3", wrPulse3, 0);
        checkOutput("rst regq3 any", |regQ3, 0);
        checkOutput("rst reg1 fast", regQ0[32 +: 32], 0);
        checkOutput("rst reg3 ro fast", regQ0[3*32 +: 32], 32'hC0FFEE03);
        @(posedge pclk); #1;
        applyStimulus(12'h014, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, rd, er, pu, wt);
        checkOutput("post-rst read waits", wt, 3);
        checkOutput("post-rst read data", rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb4_reg_slave.md
APB4_REG_SLAVE -- requirements
Module: apb4_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning paddr width.
REQ-002 SHALL have parameter DATA_W, default 32 (legal 32 or 64), meaning data width.
REQ-003 SHALL have parameter NUM_REGS, default 16 (1..256), meaning register count.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0 (0..15), meaning wait states inserted per transfer.
REQ-005 SHALL have parameter RO_MASK, default all-zero, NUM_REGS bits; a 1 marks a register as read-only, hardware-sourced.
REQ-006 SHALL have port pclk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port preset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports paddr in ADDR_W, psel in 1, penable in 1, pwrite in 1: APB4 request.
REQ-009 SHALL have port pwdata  in  DATA_W  write data.
REQ-010 SHALL have port pstrb  in  DATA_W/8  byte write strobes.
REQ-011 SHALL have port pprot  in  3  protection attributes; bit0 = privileged.
REQ-012 SHALL have ports prdata out DATA_W, pready out 1, pslverr out 1: APB4 response.
REQ-013 SHALL have port reg_q  out  NUM_REGS*DATA_W  flat current register values.
REQ-014 SHALL have port hw_in  in  NUM_REGS*DATA_W  read values for RO_MASK registers.
REQ-015 SHALL have port wr_pulse  out  NUM_REGS  one-cycle pulse per committed write.

Function
REQ-016 SHALL decode index = paddr[ADDR_W-1:log2(DATA_W/8)]; bits below are the byte offset.
REQ-017 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-018 IDLE: on psel=1 and penable=0 (setup), SHALL latch paddr/pwrite/pwdata/pstrb/pprot, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-019 WAIT: SHALL decrement the counter each cycle while psel=1; when counter=0 and psel=penable=1, SHALL go to RESP.
REQ-020 RESP: SHALL drive pready=1 for exactly one cycle, then return to IDLE; pready SHALL be registered; pready=1 in the access cycle when WAIT_CYCLES=0.
REQ-021 Error (pslverr=1 with pready): index >= NUM_REGS, nonzero byte offset, or write to an RO_MASK register.
REQ-022 On error SHALL perform no write, keep wr_pulse low, and drive prdata=0.
REQ-023 Good write SHALL update only bytes with pstrb[i]=1, commit in the RESP cycle, and pulse wr_pulse[index] that cycle; pstrb=0 still completes OK with no change and no pulse.
REQ-024 Good read SHALL return the register value (hw_in slice for RO registers) on prdata in the RESP cycle; prdata SHALL be 0 whenever pready=0.
REQ-025 If psel drops before RESP (abort), SHALL return to IDLE next cycle with no write, pready=0.
REQ-026 Back-to-back transfers SHALL be accepted; a setup phase in the cycle after RESP starts a new transfer.

Reset
REQ-027 preset=1 SHALL, at the next pclk edge, force IDLE, counter=0, pready=0, pslverr=0, prdata=0, wr_pulse=0, all registers=0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no write committed.

Configuration
REQ-029 With APB4_REG_SLAVE_PROT_EN defined, a write with pprot[0]=0 SHALL complete with pslverr=1 and no write; reads are unaffected.
REQ-030 Without APB4_REG_SLAVE_PROT_EN, pprot SHALL be ignored.

Structure
REQ-031 Package apb4_pkg SHALL hold the FSM state enum, pprot bit-index constants, and a byte-offset-width function.
REQ-032 Sub-module apb4_reg_bank SHALL hold the register storage, strobe merge, and read mux; the FSM stays in apb4_reg_slave.

Verification
REQ-033 WAIT_CYCLES=0, write 0xDEADBEEF to 0x004 with pstrb=0xF, then read 0x004 -> pready in access cycle, prdata=0xDEADBEEF, wr_pulse[1] for one cycle.
REQ-034 WAIT_CYCLES=3, read 0x008 -> pready asserts exactly 3 cycles after the first access cycle, with prdata valid then.
REQ-035 reg2=0x11223344, write 0xAABBCCDD with pstrb=0b0101 -> read returns 0x11BB33DD.
REQ-036 Write to 0x040 (NUM_REGS=16), to 0x006, and to an RO_MASK register -> pslverr=1 each time, no reg_q change, no wr_pulse.
REQ-037 Drop psel during WAIT, then assert preset during a later transfer -> no write, pready never asserted, outputs at reset values.
REQ-038 PROT_EN build, write with pprot=0b000 -> pslverr=1, no write; same write with pprot=0b001 -> OK.
